// File: rtl/sop_lut_eval_pkg.sv
// Shared types and constants for the runtime-programmable sum-of-products evaluator.
package sop_lut_eval_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  // Minterms 0, 1 and 7 true: the legacy three-input SOP equation.
  localparam logic [7:0] DEFAULT_MASK_3 = 8'b1000_0011;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/sop_lut_eval.sv
// Registered N-input Boolean function held as a minterm mask, reloadable over a
// serial port, with a saturating count of true evaluations.
module sop_lut_eval
  import sop_lut_eval_pkg::*;
#(
  parameter int                     N_IN         = 3,
  parameter logic [(1<<N_IN)-1:0]   DEFAULT_MASK = DEFAULT_MASK_3,
  parameter int                     CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [N_IN-1:0]  in_vec,
  output logic             out_valid,
  output logic             y,
  input  logic             cfg_start,
  input  logic             cfg_bit_valid,
  input  logic             cfg_bit,
  output logic             busy,
  output logic             cfg_done,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] hit_cnt,
  output state_t           dbg_state
);

  // Handshakes: in_valid and cfg_bit_valid are one-cycle qualifiers with no
  // backpressure; a bit is consumed on every LOAD cycle where cfg_bit_valid is high.

  localparam int M  = 1 << N_IN;
  localparam int IW = N_IN + 1;

  state_t          state;
  logic [M-1:0]    mask;
  logic [M-1:0]    shadow;
  logic [IW-1:0]   idx;
  logic            last_bit;
  logic            hit;

  assign last_bit  = (idx == IW'(M - 1));
  assign hit       = in_valid & mask[in_vec];
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      mask      <= DEFAULT_MASK;
      shadow    <= '0;
      idx       <= '0;
      y         <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      cfg_done  <= 1'b0;
    end else begin
      // Lookup uses the mask as it stood before this edge, so a swap on the
      // same edge is never seen by the vector sampled alongside the last bit.
      out_valid <= in_valid;
      if (in_valid) begin
        y <= mask[in_vec];
      end
      cfg_done <= 1'b0;

      case (state)
        ST_RUN: begin
          if (cfg_start) begin
            state <= ST_LOAD;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (cfg_bit_valid) begin
            shadow[idx[N_IN-1:0]] <= cfg_bit;
            idx                   <= idx + IW'(1);
            if (last_bit) begin
              mask     <= {cfg_bit, shadow[M-2:0]};
              state    <= ST_RUN;
              busy     <= 1'b0;
              cfg_done <= 1'b1;
              idx      <= '0;
            end
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_hit_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (hit),
    .cnt (hit_cnt)
  );

endmodule

// File: tb/tb_sop_lut_eval.sv
// Bench for sop_lut_eval: a 3-input/4-bit-counter instance checked every cycle
// against a mask-array model, plus an 8-input instance for the 256-bit load.
module tb_sop_lut_eval;
  import sop_lut_eval_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  localparam int A_CNT_MAX = 15;

  // instance A: N_IN = 3, CNT_W = 4
  logic       a_in_valid, a_out_valid, a_y;
  logic [2:0] a_in_vec;
  logic       a_cfg_start, a_cfg_bit_valid, a_cfg_bit, a_busy, a_cfg_done, a_clr_cnt;
  logic [3:0] a_hit_cnt;
  state_t     a_state;

  // instance B: N_IN = 8, CNT_W = 16, reset mask all zeros
  logic        b_in_valid, b_out_valid, b_y;
  logic [7:0]  b_in_vec;
  logic        b_cfg_start, b_cfg_bit_valid, b_cfg_bit, b_busy, b_cfg_done, b_clr_cnt;
  logic [15:0] b_hit_cnt;
  state_t      b_state;

  sop_lut_eval #(.N_IN(3), .DEFAULT_MASK(8'b1000_0011), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_vec(a_in_vec),
    .out_valid(a_out_valid), .y(a_y), .cfg_start(a_cfg_start),
    .cfg_bit_valid(a_cfg_bit_valid), .cfg_bit(a_cfg_bit), .busy(a_busy),
    .cfg_done(a_cfg_done), .clr_cnt(a_clr_cnt), .hit_cnt(a_hit_cnt),
    .dbg_state(a_state)
  );

  sop_lut_eval #(.N_IN(8), .DEFAULT_MASK(256'h0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_vec(b_in_vec),
    .out_valid(b_out_valid), .y(b_y), .cfg_start(b_cfg_start),
    .cfg_bit_valid(b_cfg_bit_valid), .cfg_bit(b_cfg_bit), .busy(b_busy),
    .cfg_done(b_cfg_done), .clr_cnt(b_clr_cnt), .hit_cnt(b_hit_cnt),
    .dbg_state(b_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [0:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of instance A ----------------
  // The function is an 8-entry truth table; a load collects 8 bits and then
  // replaces the table wholesale.
  logic [7:0] m_mask, m_shadow, t_sh;
  bit         m_loading;
  int         m_n, m_cnt;
  logic       m_y, m_ov, m_done, t_hit;
  bit         model_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_mask    <= DEFAULT_MASK_3;
      m_shadow  <= '0;
      m_loading <= 1'b0;
      m_n       <= 0;
      m_y       <= 1'b0;
      m_ov      <= 1'b0;
      m_done    <= 1'b0;
      m_cnt     <= 0;
    end else begin
      t_hit = a_in_valid && m_mask[a_in_vec];
      m_ov <= a_in_valid;
      if (a_in_valid) m_y <= m_mask[a_in_vec];
      if (a_clr_cnt) m_cnt <= 0;
      else if (t_hit && m_cnt < A_CNT_MAX) m_cnt <= m_cnt + 1;
      m_done <= 1'b0;
      if (!m_loading) begin
        if (a_cfg_start) begin
          m_loading <= 1'b1;
          m_n       <= 0;
        end
      end else if (a_cfg_bit_valid) begin
        t_sh = m_shadow;
        t_sh[m_n] = a_cfg_bit;
        m_shadow <= t_sh;
        if (m_n == 7) begin
          m_mask    <= t_sh;
          m_loading <= 1'b0;
          m_done    <= 1'b1;
        end else begin
          m_n <= m_n + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("a_out_valid", a_out_valid, m_ov);
      chk("a_y", a_y, m_y);
      chk("a_busy", a_busy, m_loading);
      chk("a_cfg_done", a_cfg_done, m_done);
      chk("a_hit_cnt", a_hit_cnt, m_cnt);
      chk("a_state", a_state, m_loading);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic a_eval(input logic [2:0] v, input logic exp_y);
    a_in_valid = 1'b1;
    a_in_vec   = v;
    @(negedge clk);
    a_in_valid = 1'b0;
    chk("a_eval_y", a_y, exp_y);
  endtask

  // Loads mask m; gaps inserted after bit indices gap_a/gap_b. With eval_edge
  // set, in_vec=7 is evaluated with the last bit and again on the next edge.
  task automatic a_load(input logic [7:0] m, input int gap_a, input int gap_b,
                        input bit eval_edge, input logic y_old, input logic y_new);
    a_cfg_start = 1'b1;
    @(negedge clk);
    a_cfg_start = 1'b0;
    chk("load_busy_start", a_busy, 1);
    for (int k = 0; k < 8; k++) begin
      a_cfg_bit_valid = 1'b1;
      a_cfg_bit       = m[k];
      if (k == 3) a_cfg_start = 1'b1;
      if (k == 7 && eval_edge) begin
        a_in_valid = 1'b1;
        a_in_vec   = 3'd7;
      end
      @(negedge clk);
      a_cfg_start     = 1'b0;
      a_cfg_bit_valid = 1'b0;
      if (k < 7) begin
        chk("load_busy_mid", a_busy, 1);
        chk("load_done_early", a_cfg_done, 0);
      end
      if (k == gap_a || k == gap_b) begin
        @(negedge clk);
        chk("load_busy_gap", a_busy, 1);
      end
    end
    chk("load_done_pulse", a_cfg_done, 1);
    chk("load_busy_end", a_busy, 0);
    if (eval_edge) chk("swap_old_mask", a_y, y_old);
    @(negedge clk);
    a_in_valid = 1'b0;
    chk("load_done_once", a_cfg_done, 0);
    if (eval_edge) chk("swap_new_mask", a_y, y_new);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    a_in_valid = 0; a_in_vec = '0; a_cfg_start = 0; a_cfg_bit_valid = 0;
    a_cfg_bit = 0; a_clr_cnt = 0;
    b_in_valid = 0; b_in_vec = '0; b_cfg_start = 0; b_cfg_bit_valid = 0;
    b_cfg_bit = 0; b_clr_cnt = 0;
    repeat (2) @(negedge clk);
    model_on = 1'b1;
    chk("rst_y", a_y, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_cfg_done, 0);
    chk("rst_hit_cnt", a_hit_cnt, 0);
    rst = 1'b0;

    // default mask sweep
    exp_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1'b1;
      a_in_vec   = 3'(i);
      @(negedge clk);
      chk("sweep_y", a_y, exp_q.pop_front());
      chk("sweep_out_valid", a_out_valid, 1);
    end
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("sweep_hit_cnt", a_hit_cnt, 3);
    chk("idle_out_valid", a_out_valid, 0);
    chk("idle_y_holds", a_y, 1);

    // config bits in RUN are ignored
    a_cfg_bit_valid = 1'b1; a_cfg_bit = 1'b1;
    @(negedge clk);
    a_cfg_bit_valid = 1'b0;
    chk("run_ignores_bits", a_busy, 0);

    // load 0110_1001 with gaps after bits 2 and 5
    a_load(8'b0110_1001, 2, 5, 1'b0, 1'b0, 1'b0);
    a_eval(3'b011, 1'b1);
    a_eval(3'b111, 1'b0);

    // reset mid-load restores the default mask
    a_cfg_start = 1'b1;
    @(negedge clk);
    a_cfg_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a_cfg_bit_valid = 1'b1; a_cfg_bit = 1'b0;
      @(negedge clk);
    end
    a_cfg_bit_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", a_busy, 0);
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_done", a_cfg_done, 0);
    end
    a_eval(3'b001, 1'b1);
    a_eval(3'b111, 1'b1);

    // swap boundary: default mask has minterm 7, new one does not
    a_load(8'b0110_1001, -1, -1, 1'b1, 1'b1, 1'b0);

    // saturation and clear priority (minterm 0 true in 0110_1001)
    a_clr_cnt = 1'b1;
    @(negedge clk);
    a_clr_cnt = 1'b0;
    a_in_valid = 1'b1; a_in_vec = 3'd0;
    repeat (20) @(negedge clk);
    a_in_valid = 1'b0;
    chk("sat_hit_cnt", a_hit_cnt, 15);
    a_in_valid = 1'b1; a_clr_cnt = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0; a_clr_cnt = 1'b0;
    chk("clr_priority", a_hit_cnt, 0);

    // 8-input instance: 256-bit all-ones load
    b_in_valid = 1'b1; b_in_vec = 8'hFF;
    @(negedge clk);
    b_in_valid = 1'b0;
    chk("b_before_y", b_y, 0);
    b_cfg_start = 1'b1;
    @(negedge clk);
    b_cfg_start = 1'b0;
    for (int k = 0; k < 256; k++) begin
      b_cfg_bit_valid = 1'b1; b_cfg_bit = 1'b1;
      @(negedge clk);
      if (k == 254) begin
        chk("b_busy_before_last", b_busy, 1);
        chk("b_done_before_last", b_cfg_done, 0);
      end
    end
    b_cfg_bit_valid = 1'b0;
    chk("b_done_pulse", b_cfg_done, 1);
    chk("b_busy_end", b_busy, 0);
    b_in_valid = 1'b1; b_in_vec = 8'hFF;
    @(negedge clk);
    chk("b_done_once", b_cfg_done, 0);
    chk("b_after_y_ff", b_y, 1);
    b_in_vec = 8'h00;
    @(negedge clk);
    b_in_valid = 1'b0;
    chk("b_after_y_00", b_y, 1);
    @(negedge clk);
    chk("b_hit_cnt", b_hit_cnt, 2);

    // ---------------- final report ----------------
    model_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
